// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: shared definitions for the UART command decoder.
//   - ASCII command byte constants (lower case; upper case is folded before lookup)
//   - Pulse bit indices for ascii_d and mode-register indices
//   - FSM state encoding
//   - decode_cmd(): maps one received byte to pulse / toggle / error fields
package uart_cmd_pkg;

  // Action commands
  localparam logic [7:0] AsciiRunStop = 8'h72;  // 'r'
  localparam logic [7:0] AsciiClear   = 8'h63;  // 'c'
  localparam logic [7:0] AsciiUp      = 8'h75;  // 'u'
  localparam logic [7:0] AsciiDown    = 8'h64;  // 'd'
  localparam logic [7:0] AsciiSpare   = 8'h78;  // 'x'

  // Mode toggles
  localparam logic [7:0] AsciiUpDown  = 8'h6D;  // 'm'
  localparam logic [7:0] AsciiStopw   = 8'h77;  // 'w'
  localparam logic [7:0] AsciiHmSms   = 8'h68;  // 'h'
  localparam logic [7:0] AsciiWatchSt = 8'h73;  // 's'
  localparam logic [7:0] AsciiHumiTmp = 8'h74;  // 't'

  // Silently consumed bytes
  localparam logic [7:0] AsciiCr      = 8'h0D;
  localparam logic [7:0] AsciiLf      = 8'h0A;
  localparam logic [7:0] AsciiSpace   = 8'h20;

  // ascii_d bit indices
  localparam int unsigned RUN_STOP = 0;
  localparam int unsigned CLEAR    = 1;
  localparam int unsigned UP       = 2;
  localparam int unsigned DOWN     = 3;
  localparam int unsigned SPARE    = 4;

  // Mode register indices
  localparam int unsigned MODE_UP_DOWN   = 0;
  localparam int unsigned MODE_STOPW     = 1;
  localparam int unsigned MODE_HM_SMS    = 2;
  localparam int unsigned MODE_WATCH_SET = 3;
  localparam int unsigned MODE_HUMI_TEMP = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StEmit = 2'd1,
    StGap  = 2'd2
  } state_e;

  typedef struct packed {
    logic [4:0] pulse;
    logic [4:0] toggle;
    logic       err;
  } cmd_t;

  function automatic cmd_t decode_cmd(input logic [7:0] b);
    cmd_t       c;
    logic [7:0] lc;
    c  = '0;
    lc = b;
    // Fold A-Z onto a-z; other bytes pass through unchanged
    if (b >= 8'h41 && b <= 8'h5A) begin
      lc = b | 8'h20;
    end
    case (lc)
      AsciiRunStop: c.pulse[RUN_STOP]        = 1'b1;
      AsciiClear:   c.pulse[CLEAR]           = 1'b1;
      AsciiUp:      c.pulse[UP]              = 1'b1;
      AsciiDown:    c.pulse[DOWN]            = 1'b1;
      AsciiSpare:   c.pulse[SPARE]           = 1'b1;
      AsciiUpDown:  c.toggle[MODE_UP_DOWN]   = 1'b1;
      AsciiStopw:   c.toggle[MODE_STOPW]     = 1'b1;
      AsciiHmSms:   c.toggle[MODE_HM_SMS]    = 1'b1;
      AsciiWatchSt: c.toggle[MODE_WATCH_SET] = 1'b1;
      AsciiHumiTmp: c.toggle[MODE_HUMI_TEMP] = 1'b1;
      AsciiCr, AsciiLf, AsciiSpace: ;
      default:      c.err                    = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: synchronous FIFO with first-word fall-through head (dout = current head).
// Ports:
//   clk, reset      - clock, synchronous active-high reset (empties the FIFO)
//   wr_en, din      - write request and data; ignored while full
//   rd_en, dout     - pop request and head data; ignored while empty
//   full, empty     - status from the registered count (pre-pop)
module cmd_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned CntW  = AddrW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AddrW-1:0] r_wr_ptr;
  logic [AddrW-1:0] r_rd_ptr;
  logic [CntW-1:0]  r_count;

  logic w_wr;
  logic w_rd;

  assign full  = (r_count == CntW'(DEPTH));
  assign empty = (r_count == '0);
  assign dout  = r_mem[r_rd_ptr];

  // Fullness uses the count before any same-cycle pop, so a write into a
  // full FIFO is dropped even if the head is leaving this cycle.
  assign w_wr = wr_en && !full;
  assign w_rd = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= din;
        r_wr_ptr        <= r_wr_ptr + AddrW'(1);
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + AddrW'(1);
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder: buffers UART RX bytes and turns each into either a one-cycle
// action pulse on ascii_d or a flip of one mode register, with GAP_CYCLES idle
// cycles after every consumed byte.
// Ports:
//   clk, reset              - clock, synchronous active-high reset
//   rx_data, rx_done        - received byte and its one-cycle strobe
//   ascii_d[4:0]            - one-hot action pulses (run/stop, clear, up, down, spare)
//   ascii_up_down, ascii_stopwatch_watch, ascii_hm_sms,
//   ascii_watch_set, ascii_humi_temp - toggled mode registers
//   o_overflow              - sticky, a byte was dropped on a full FIFO
//   o_err_cnt               - saturating count of unrecognised bytes
//   o_busy                  - FIFO non-empty or FSM not idle
module uart_cmd_decoder
  import uart_cmd_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic [4:0] ascii_d,
  output logic       ascii_up_down,
  output logic       ascii_stopwatch_watch,
  output logic       ascii_hm_sms,
  output logic       ascii_watch_set,
  output logic       ascii_humi_temp,
  output logic       o_overflow,
  output logic [7:0] o_err_cnt,
  output logic       o_busy
);

  localparam int unsigned GapW = $clog2(GAP_CYCLES + 1);

  logic [7:0]  w_head;
  logic        w_full;
  logic        w_empty;
  logic        w_rd_en;
  cmd_t        w_cmd;

  state_e      r_state;
  state_e      w_state_next;
  logic [GapW-1:0] r_gap_cnt;
  logic [GapW-1:0] w_gap_cnt_next;

  logic [4:0]  r_ascii_d;
  logic [4:0]  r_modes;
  logic        r_overflow;
  logic [7:0]  r_err_cnt;

  cmd_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .wr_en (rx_done),
    .rd_en (w_rd_en),
    .din   (rx_data),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty)
  );

  assign w_cmd = decode_cmd(w_head);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= StIdle;
      r_gap_cnt <= '0;
    end else begin
      r_state   <= w_state_next;
      r_gap_cnt <= w_gap_cnt_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_gap_cnt_next = r_gap_cnt;
    w_rd_en        = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (!w_empty) begin
          w_rd_en      = 1'b1;
          w_state_next = StEmit;
        end
      end
      StEmit: begin
        w_gap_cnt_next = GapW'(GAP_CYCLES);
        w_state_next   = StGap;
      end
      StGap: begin
        w_gap_cnt_next = r_gap_cnt - GapW'(1);
        // Counter reaching zero on this decrement ends the gap
        if (r_gap_cnt == GapW'(1)) begin
          w_state_next = StIdle;
        end
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // The pulse register is loaded on the pop edge (entering EMIT) and cleared on
  // the next edge, so ascii_d is high exactly for the EMIT cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ascii_d  <= '0;
      r_modes    <= '0;
      r_overflow <= 1'b0;
      r_err_cnt  <= '0;
    end else begin
      r_ascii_d <= '0;
      if (w_rd_en) begin
        r_ascii_d <= w_cmd.pulse;
        r_modes   <= r_modes ^ w_cmd.toggle;
        if (w_cmd.err && (r_err_cnt != 8'hFF)) begin
          r_err_cnt <= r_err_cnt + 8'd1;
        end
      end
      if (rx_done && w_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign ascii_d               = r_ascii_d;
  assign ascii_up_down         = r_modes[MODE_UP_DOWN];
  assign ascii_stopwatch_watch = r_modes[MODE_STOPW];
  assign ascii_hm_sms          = r_modes[MODE_HM_SMS];
  assign ascii_watch_set       = r_modes[MODE_WATCH_SET];
  assign ascii_humi_temp       = r_modes[MODE_HUMI_TEMP];
  assign o_overflow            = r_overflow;
  assign o_err_cnt             = r_err_cnt;
  assign o_busy                = !w_empty || (r_state != StIdle);

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Scoreboard bench for uart_cmd_decoder (default FIFO_DEPTH=4, GAP_CYCLES=2).
// Stimulus pushes expected {pulse, cycle} entries; a negedge monitor pops one
// entry per observed ascii_d pulse and compares value and cycle.
module tb_uart_cmd_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done = 1'b0;
  logic [4:0] ascii_d;
  logic       ascii_up_down;
  logic       ascii_stopwatch_watch;
  logic       ascii_hm_sms;
  logic       ascii_watch_set;
  logic       ascii_humi_temp;
  logic       o_overflow;
  logic [7:0] o_err_cnt;
  logic       o_busy;

  uart_cmd_decoder #(
    .FIFO_DEPTH (4),
    .GAP_CYCLES (2)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .rx_data               (rx_data),
    .rx_done               (rx_done),
    .ascii_d               (ascii_d),
    .ascii_up_down         (ascii_up_down),
    .ascii_stopwatch_watch (ascii_stopwatch_watch),
    .ascii_hm_sms          (ascii_hm_sms),
    .ascii_watch_set       (ascii_watch_set),
    .ascii_humi_temp       (ascii_humi_temp),
    .o_overflow            (o_overflow),
    .o_err_cnt             (o_err_cnt),
    .o_busy                (o_busy)
  );

  always #5 clk = ~clk;

  // Cycle n is the interval after the n-th rising edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [4:0] v;
    int         c;
  } exp_t;
  exp_t sb[$];

  logic [4:0] modes;
  assign modes = {ascii_humi_temp, ascii_watch_set, ascii_hm_sms,
                  ascii_stopwatch_watch, ascii_up_down};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_pulse(input int idx, input int c);
    exp_t e;
    e.v = 5'b00001 << idx;
    e.c = c;
    sb.push_back(e);
  endtask

  task automatic put(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_data = b;
    rx_done = 1'b1;
  endtask

  task automatic stop_rx();
    @(posedge clk);
    #1;
    rx_done = 1'b0;
    rx_data = 8'h00;
  endtask

  // Advance to the sampling point (negedge) of cycle c.
  task automatic at_cycle(input int c);
    forever begin
      @(negedge clk);
      if (cyc >= c) break;
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (o_busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (o_busy) begin
      bad++;
      $display("FAIL %s: o_busy still 1 after 200 cycles, want 0", name);
    end
  endtask

  // Monitor: every pulse must match the head of the scoreboard in value and cycle.
  always @(negedge clk) begin
    exp_t e;
    if (ascii_d !== 5'b00000) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL pulse_unexpected: got %b at cycle %0d, want no pulse", ascii_d, cyc);
      end else begin
        e = sb.pop_front();
        if (ascii_d !== e.v || cyc != e.c) begin
          bad++;
          $display("FAIL pulse: got %b at cycle %0d, want %b at cycle %0d",
                   ascii_d, cyc, e.v, e.c);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish, want finish");
    $fatal(1);
  end

  initial begin
    int         t0;
    logic [7:0] burst [5];
    logic [7:0] ovf   [6];

    // Reset state
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_ascii_d", ascii_d, 5'd0);
    check("rst_modes", modes, 5'd0);
    check("rst_overflow", o_overflow, 1'b0);
    check("rst_err_cnt", o_err_cnt, 8'd0);
    check("rst_busy", o_busy, 1'b0);

    // Single byte: pulse at T+2, busy high T+1..T+4, low at T+5
    put("r");
    t0 = cyc;
    push_pulse(0, t0 + 2);
    stop_rx();
    at_cycle(t0 + 1);
    check("single_busy_rise", o_busy, 1'b1);
    at_cycle(t0 + 4);
    check("single_busy_t4", o_busy, 1'b1);
    at_cycle(t0 + 5);
    check("single_busy_fall", o_busy, 1'b0);

    // Burst R c u D x: head pops at T+1, so five bytes fit in four entries
    burst = '{8'h52, 8'h63, 8'h75, 8'h44, 8'h78};
    for (int k = 0; k < 5; k++) begin
      put(burst[k]);
      if (k == 0) t0 = cyc;
      push_pulse(k, t0 + 2 + 4 * k);
    end
    stop_rx();
    wait_idle("burst_drain");
    check("burst_no_overflow", o_overflow, 1'b0);

    // Toggles m M w: flips visible at T+2, T+6, T+10
    put("m");
    t0 = cyc;
    put("M");
    put("w");
    at_cycle(t0 + 2);
    check("tog_ud_set", ascii_up_down, 1'b1);
    stop_rx();
    at_cycle(t0 + 5);
    check("tog_ud_hold", ascii_up_down, 1'b1);
    at_cycle(t0 + 6);
    check("tog_ud_clr", ascii_up_down, 1'b0);
    at_cycle(t0 + 9);
    check("tog_sw_before", ascii_stopwatch_watch, 1'b0);
    at_cycle(t0 + 10);
    check("tog_modes_final", modes, 5'b00010);
    wait_idle("tog_drain");

    // Errors: z and 9 count, CR and LF do not
    put("z");
    put(8'h0D);
    put(8'h0A);
    put("9");
    stop_rx();
    wait_idle("err_drain");
    check("err_cnt_2", o_err_cnt, 8'd2);

    for (int i = 0; i < 300; i++) begin
      put(8'h80 + 8'(i % 16));
      stop_rx();
      wait_idle("err_loop_drain");
      if (i == 249) check("err_cnt_252", o_err_cnt, 8'd252);
    end
    check("err_cnt_sat", o_err_cnt, 8'd255);

    // Overflow: six bytes back to back; the sixth meets a full FIFO and is dropped
    ovf = '{"r", "c", "u", "d", "x", "r"};
    for (int k = 0; k < 6; k++) begin
      put(ovf[k]);
      if (k == 0) t0 = cyc;
      if (k < 5) push_pulse(k, t0 + 2 + 4 * k);
    end
    at_cycle(t0 + 5);
    check("ovf_before", o_overflow, 1'b0);
    stop_rx();
    at_cycle(t0 + 6);
    check("ovf_set", o_overflow, 1'b1);
    wait_idle("ovf_drain");
    check("ovf_sticky", o_overflow, 1'b1);
    check("ovf_err_unchanged", o_err_cnt, 8'd255);

    // Reset during the GAP following the first pulse of a queued burst
    put("r");
    t0 = cyc;
    push_pulse(0, t0 + 2);
    put("c");
    put("u");
    @(posedge clk);
    #1;
    rx_done = 1'b0;
    reset   = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    at_cycle(t0 + 4);
    check("mid_rst_ascii_d", ascii_d, 5'd0);
    check("mid_rst_modes", modes, 5'd0);
    check("mid_rst_overflow", o_overflow, 1'b0);
    check("mid_rst_err_cnt", o_err_cnt, 8'd0);
    check("mid_rst_busy", o_busy, 1'b0);
    repeat (20) @(negedge clk);
    check("mid_rst_stay_idle", o_busy, 1'b0);

    check("scoreboard_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
